input_debouncer: RTL and testbench

Input conditioning stage that sits directly upstream of the pattern-detecting Moore state machine and produces its clean `in` bit. Synchronises an asynchronous raw input through a flip-flop chain, then debounces it so the output changes only after the synchronised value is stable for a programmable number of consecutive cycles. Optional one-cycle edge pulses are also provided for counters and interrupt logic.

---
 rtl/input_debouncer_pkg.sv | 14 +
 rtl/input_debouncer_sync_chain.sv | 23 ++
 rtl/input_debouncer.sv | 122 ++++++++++++
 tb/tb_input_debouncer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared state encoding and default parameters for input_debouncer
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } DebounceState;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// rtl/input_debouncer_sync_chain.sv - module sync_chain, depth-N flop chain for asynchronous inputs
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce rawIn; rise/fall pulses only when DEBOUNCE_EDGE_EN is defined
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic rawIn,
    output logic cleanOut,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    DebounceState     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;

    sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rawIn),
        .q_o (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                    end else begin
                        state_d = CHECK_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                    end else begin
                        state_d = CHECK_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registered from next state so cleanOut changes on the deciding edge
    assign clean_d = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign cleanOut = clean_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= clean_d & ~clean_q;
            fall_q <= ~clean_d & clean_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer (default and STABLE_CYCLES=1)
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b0;
    logic raw_in1 = 1'b0;
    logic clean_out, rise, fall;
    logic clean_out1, rise1, fall1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    input_debouncer u_dut (
        .clk      (clk),
        .rst      (rst),
        .rawIn    (raw_in),
        .cleanOut (clean_out),
        .rise     (rise),
        .fall     (fall)
    );

    input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .rawIn    (raw_in1),
        .cleanOut (clean_out1),
        .rise     (rise1),
        .fall     (fall1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_in = 1'b0;
        raw_in1 = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({clean_out, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_dut got=%b%b%b exp=000", clean_out, rise, fall);
        end
        n_checks++;
        if ({clean_out1, rise1, fall1} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_dut1 got=%b%b%b exp=000", clean_out1, rise1, fall1);
        end
    endtask

    task automatic check_rise_window(input string tag);
        logic exp_clean, exp_rise;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e >= 5);
            exp_rise  = EDGE_EN && (e == 5);
            n_checks++;
            if (clean_out !== exp_clean) begin
                n_fail++;
                $display("FAIL %s_clean edge=%0d got=%b exp=%b", tag, e, clean_out, exp_clean);
            end
            n_checks++;
            if (rise !== exp_rise || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_edge edge=%0d rise=%b fall=%b exp_rise=%b exp_fall=0", tag, e, rise, fall, exp_rise);
            end
        end
    endtask

    task automatic test_rise_latency();
        rst = 1'b0;
        raw_in = 1'b1;
        check_rise_window("rise_latency");
    endtask

    task automatic test_short_glitch();
        raw_in = 1'b0;
        repeat (12) tick();
        raw_in = 1'b1;
        for (int e = 0; e < 11; e++) begin
            tick();
            if (e == 2) raw_in = 1'b0;
            n_checks++;
            if (clean_out !== 1'b0 || rise !== 1'b0) begin
                n_fail++;
                $display("FAIL short_glitch edge=%0d clean=%b rise=%b exp=0/0", e, clean_out, rise);
            end
        end
    endtask

    task automatic test_fall_latency();
        logic exp_clean, exp_fall;
        raw_in = 1'b1;
        repeat (12) tick();
        raw_in = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_clean = (e < 5);
            exp_fall  = EDGE_EN && (e == 5);
            n_checks++;
            if (clean_out !== exp_clean) begin
                n_fail++;
                $display("FAIL fall_latency_clean edge=%0d got=%b exp=%b", e, clean_out, exp_clean);
            end
            n_checks++;
            if (fall !== exp_fall || rise !== 1'b0) begin
                n_fail++;
                $display("FAIL fall_latency_edge edge=%0d fall=%b rise=%b exp_fall=%b exp_rise=0", e, fall, rise, exp_fall);
            end
        end
    endtask

    task automatic test_bounce();
        logic [12:0] pattern;
        raw_in = 1'b1;
        repeat (12) tick();
        // 0,1,0,0,1 then held high; longest low run is two samples
        pattern = 13'b1111_1111_10010;
        for (int e = 0; e < 13; e++) begin
            raw_in = pattern[e];
            tick();
            n_checks++;
            if (clean_out !== 1'b1 || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce edge=%0d clean=%b fall=%b exp=1/0", e, clean_out, fall);
            end
        end
    endtask

    task automatic test_single_pulse_fast();
        logic exp_clean, exp_rise, exp_fall;
        raw_in1 = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            if (e == 0) raw_in1 = 1'b0;
            exp_clean = (e == 2);
            exp_rise  = EDGE_EN && (e == 2);
            exp_fall  = EDGE_EN && (e == 3);
            n_checks++;
            if (clean_out1 !== exp_clean) begin
                n_fail++;
                $display("FAIL fast_pulse_clean edge=%0d got=%b exp=%b", e, clean_out1, exp_clean);
            end
            n_checks++;
            if (rise1 !== exp_rise || fall1 !== exp_fall) begin
                n_fail++;
                $display("FAIL fast_pulse_edge edge=%0d rise=%b fall=%b exp=%b/%b", e, rise1, fall1, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        rst = 1'b1;
        raw_in = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        raw_in = 1'b1;
        // after edge 3 the FSM sits in CHECK_HIGH with cnt=2
        for (int e = 0; e <= 3; e++) begin
            tick();
            n_checks++;
            if (clean_out !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_check_pre edge=%0d got=%b exp=0", e, clean_out);
            end
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({clean_out, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_check_reset got=%b%b%b exp=000", clean_out, rise, fall);
        end
        rst = 1'b0;
        check_rise_window("mid_check_release");
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_short_glitch();
        test_fall_latency();
        test_bounce();
        test_single_pulse_fast();
        test_reset_mid_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
